// File: rtl/seg_scan_multi.sv
// rtl/seg_scan_multi.sv - multiplexed 7-segment scanner with guard, blanking and double-buffered load
//
// Scans DIGITS common-select digits from a packed nibble word. Each digit
// slot is CNT_MS cycles of drive followed by BLANK_CYC cycles with every
// select off, so segment changes never ghost onto a neighbouring digit.
//
// Ports:
//   sys_clk     clock
//   sys_rst_n   asynchronous reset, active-high
//   data        nibble i drives digit i (digit 0 rightmost)
//   dp_en       decimal point per digit
//   digit_en    digit i lit only when bit i is set
//   lz_blank    leading-zero blanking enable (live, not buffered)
//   load        captures data/dp_en/digit_en into the pending buffer
//   seg         {a,b,c,d,e,f,g,dp}, registered, polarity per SEG_ACT_LOW
//   sel         one-hot digit select, registered, polarity per SEL_ACT_LOW
//   frame_done  pulse in the first output cycle of digit 0 of a new frame
module seg_scan_multi #(
    parameter int DIGITS      = 4,
    parameter int CNT_MS      = 15000,
    parameter int BLANK_CYC   = 100,
    parameter int SEG_ACT_LOW = 0,
    parameter int SEL_ACT_LOW = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_blank,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int CNT_MAX = (CNT_MS > BLANK_CYC) ? CNT_MS : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     SCAN_LAST  = CW'(CNT_MS - 1);
    localparam logic [CW-1:0]     GUARD_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_INV    = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_INV    = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic {
        SCAN  = 1'b0,
        GUARD = 1'b1
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic                wrap_q;

    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   shadow_en;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_en;
    logic                pend_valid;

    logic                slot_done;
    logic                wrap;
    logic [IW-1:0]       next_idx;
    logic [3:0]          nib;
    logic                zero_run;
    logic                lz_hit;
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   sel_n;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hFC;
            4'h1: glyph = 8'h60;
            4'h2: glyph = 8'hDA;
            4'h3: glyph = 8'hF2;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'hB6;
            4'h6: glyph = 8'hBE;
            4'h7: glyph = 8'hE0;
            4'h8: glyph = 8'hFE;
            4'h9: glyph = 8'hF6;
            4'hA: glyph = 8'hEE;
            4'hB: glyph = 8'h3E;
            4'hC: glyph = 8'h9C;
            4'hD: glyph = 8'h7A;
            4'hE: glyph = 8'h9E;
            default: glyph = 8'h8E;
        endcase
    endfunction

    always_comb begin
        // A digit slot ends after the guard, or straight after SCAN when there is no guard.
        slot_done = ((state == SCAN) && (cnt == SCAN_LAST) && (BLANK_CYC == 0)) ||
                    ((state == GUARD) && (cnt == GUARD_LAST));
        wrap      = slot_done && (idx == IDX_LAST);
        next_idx  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        nib       = shadow_data[{idx, 2'b00} +: 4];

        // Walk from the most significant digit down; zero_run stays set while
        // every nibble seen so far is zero. Digit 0 is never tested.
        zero_run = 1'b1;
        lz_hit   = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (shadow_data[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                lz_hit = zero_run;
            end
        end

        seg_n = 8'h00;
        sel_n = '0;
        if (state == SCAN && shadow_en[idx]) begin
            sel_n[idx] = 1'b1;
            seg_n      = ((lz_blank && lz_hit) ? 8'h00 : glyph(nib)) | {7'b0, shadow_dp[idx]};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state       <= SCAN;
            idx         <= '0;
            cnt         <= '0;
            wrap_q      <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_en   <= '1;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_en     <= '1;
            pend_valid  <= 1'b0;
            seg         <= SEG_INV;
            sel         <= SEL_INV;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (BLANK_CYC != 0) begin
                            state <= GUARD;
                        end else begin
                            idx <= next_idx;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= SCAN;
                        idx   <= next_idx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase

            // A load landing on the wrap edge bypasses pending so it is not
            // delayed a whole frame.
            if (wrap) begin
                pend_valid <= 1'b0;
                if (load) begin
                    shadow_data <= data;
                    shadow_dp   <= dp_en;
                    shadow_en   <= digit_en;
                end else if (pend_valid) begin
                    shadow_data <= pend_data;
                    shadow_dp   <= pend_dp;
                    shadow_en   <= pend_en;
                end
            end else if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_en;
                pend_en    <= digit_en;
                pend_valid <= 1'b1;
            end

            // Outputs trail state by one cycle, so frame_done needs the same
            // extra stage to line up with the first digit-0 output cycle.
            wrap_q     <= wrap;
            frame_done <= wrap_q;
            seg        <= seg_n ^ SEG_INV;
            sel        <= sel_n ^ SEL_INV;
        end
    end

endmodule

// File: tb/tb_seg_scan_multi.sv
// tb/tb_seg_scan_multi.sv - scoreboard bench for seg_scan_multi
module tb_seg_scan_multi;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] data;
    logic [3:0]  dp_en;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        load;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        frame_done;
    logic [7:0]  seg_i;
    logic [3:0]  sel_i;
    logic        fd_i;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       dc;
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    seg_scan_multi #(
        .DIGITS(4), .CNT_MS(10), .BLANK_CYC(2), .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .dp_en(dp_en),
        .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
        .seg(seg), .sel(sel), .frame_done(frame_done)
    );

    seg_scan_multi #(
        .DIGITS(4), .CNT_MS(10), .BLANK_CYC(0), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
    ) dut_inv (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .dp_en(dp_en),
        .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
        .seg(seg_i), .sel(sel_i), .frame_done(fd_i)
    );

    function automatic logic [7:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'h0: ref_glyph = 8'hFC;  4'h1: ref_glyph = 8'h60;
            4'h2: ref_glyph = 8'hDA;  4'h3: ref_glyph = 8'hF2;
            4'h4: ref_glyph = 8'h66;  4'h5: ref_glyph = 8'hB6;
            4'h6: ref_glyph = 8'hBE;  4'h7: ref_glyph = 8'hE0;
            4'h8: ref_glyph = 8'hFE;  4'h9: ref_glyph = 8'hF6;
            4'hA: ref_glyph = 8'hEE;  4'hB: ref_glyph = 8'h3E;
            4'hC: ref_glyph = 8'h9C;  4'hD: ref_glyph = 8'h7A;
            4'hE: ref_glyph = 8'h9E;  default: ref_glyph = 8'h8E;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        data     = d;
        dp_en    = dp;
        digit_en = en;
        load     = 1'b1;
        @(negedge sys_clk);
        load     = 1'b0;
    endtask

    // Expected outputs for one whole frame starting at its frame_done cycle.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                              input logic lz, input logic inv);
        exp_t e;
        logic [3:0] nibv;
        logic [7:0] s;
        logic [3:0] one;
        logic blank;
        int guard;
        guard = inv ? 0 : 2;
        for (int dg = 0; dg < 4; dg++) begin
            nibv  = d[4*dg +: 4];
            blank = lz && (dg != 0) && ((d >> (4*dg)) == 16'h0);
            s     = (blank ? 8'h00 : ref_glyph(nibv)) | {7'b0, dp[dg]};
            one   = 4'(1 << dg);
            for (int k = 0; k < 10; k++) begin
                e.dc  = !en[dg];
                e.seg = inv ? ~s : s;
                e.sel = en[dg] ? (inv ? ~one : one) : (inv ? 4'hF : 4'h0);
                e.fd  = (dg == 0) && (k == 0);
                exp_q.push_back(e);
            end
            for (int k = 0; k < guard; k++) begin
                e.dc  = 1'b0;
                e.seg = inv ? 8'hFF : 8'h00;
                e.sel = inv ? 4'hF : 4'h0;
                e.fd  = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_frame(input string name, input logic inv, input int n);
        exp_t e;
        logic [7:0] a_seg;
        logic [3:0] a_sel;
        logic a_fd;
        for (int i = 0; i < n; i++) begin
            e     = exp_q.pop_front();
            a_seg = inv ? seg_i : seg;
            a_sel = inv ? sel_i : sel;
            a_fd  = inv ? fd_i : frame_done;
            checks++;
            if ((!e.dc && a_seg !== e.seg) || a_sel !== e.sel || a_fd !== e.fd) begin
                errors++;
                $display("FAIL %s cyc %0d: seg=%h sel=%b fd=%b expected seg=%h sel=%b fd=%b",
                         name, i, a_seg, a_sel, a_fd, e.seg, e.sel, e.fd);
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic wait_frame_done(input logic inv);
        for (int i = 0; i < 150; i++) begin
            @(negedge sys_clk);
            if ((inv ? fd_i : frame_done) === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_frame_done: no pulse within 150 cycles, required one");
    endtask

    task automatic test_reset;
        checks += 5;
        if (seg !== 8'h00)      begin errors++; $display("FAIL reset_seg: %h required 00", seg); end
        if (sel !== 4'h0)       begin errors++; $display("FAIL reset_sel: %b required 0000", sel); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: %b required 0", frame_done); end
        if (seg_i !== 8'hFF)    begin errors++; $display("FAIL reset_seg_inv: %h required FF", seg_i); end
        if (sel_i !== 4'hF)     begin errors++; $display("FAIL reset_sel_inv: %b required 1111", sel_i); end
    endtask

    task automatic test_load_scan;
        int cyc;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        cyc = 1;
        checks += 4;
        if (seg !== 8'hFC)   begin errors++; $display("FAIL first_seg: %h required FC", seg); end
        if (sel !== 4'b0001) begin errors++; $display("FAIL first_sel: %b required 0001", sel); end
        if (seg_i !== 8'h03) begin errors++; $display("FAIL first_seg_inv: %h required 03", seg_i); end
        if (sel_i !== 4'b1110) begin errors++; $display("FAIL first_sel_inv: %b required 1110", sel_i); end
        step(4);
        cyc = 5;
        do_load(16'h1234, 4'h0, 4'hF);
        cyc = 6;
        while (frame_done !== 1'b1 && cyc < 200) begin
            if (sel === 4'b0001) begin
                checks++;
                if (seg !== 8'hFC) begin
                    errors++;
                    $display("FAIL old_shadow cyc %0d: seg=%h required FC", cyc, seg);
                end
            end
            @(negedge sys_clk);
            cyc++;
        end
        checks++;
        if (frame_done !== 1'b1 || cyc < 47 || cyc > 49) begin
            errors++;
            $display("FAIL first_frame_done: cycle %0d required 47..49", cyc);
        end
        push_frame(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0);
        check_frame("load_1234", 1'b0, 48);
        data  = 16'hFFFF;
        dp_en = 4'hF;
        push_frame(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0);
        check_frame("no_load", 1'b0, 48);
    endtask

    task automatic test_lz_blank;
        lz_blank = 1'b1;
        do_load(16'h0050, 4'b0100, 4'hF);
        wait_frame_done(1'b0);
        push_frame(16'h0050, 4'b0100, 4'hF, 1'b1, 1'b0);
        check_frame("lz_blank", 1'b0, 48);
    endtask

    task automatic test_digit_en;
        lz_blank = 1'b0;
        do_load(16'h1234, 4'h0, 4'b0101);
        wait_frame_done(1'b0);
        push_frame(16'h1234, 4'h0, 4'b0101, 1'b0, 1'b0);
        push_frame(16'h1234, 4'h0, 4'b0101, 1'b0, 1'b0);
        check_frame("digit_en_f1", 1'b0, 48);
        check_frame("digit_en_f2", 1'b0, 48);
    endtask

    task automatic test_back_to_back;
        step(3);
        do_load(16'hAAAA, 4'h0, 4'hF);
        step(6);
        do_load(16'hBBBB, 4'h0, 4'hF);
        wait_frame_done(1'b0);
        push_frame(16'hBBBB, 4'h0, 4'hF, 1'b0, 1'b0);
        check_frame("last_load_wins", 1'b0, 48);
        // The wrap edge is sampled two cycles before the next frame_done.
        step(46);
        do_load(16'hCCCC, 4'h0, 4'hF);
        step(1);
        push_frame(16'hCCCC, 4'h0, 4'hF, 1'b0, 1'b0);
        check_frame("boundary_load", 1'b0, 48);
    endtask

    task automatic test_polarity;
        do_load(16'h8888, 4'h0, 4'hF);
        wait_frame_done(1'b1);
        push_frame(16'h8888, 4'h0, 4'hF, 1'b0, 1'b1);
        check_frame("polarity", 1'b1, 40);
    endtask

    task automatic test_reset_midframe;
        wait_frame_done(1'b0);
        do_load(16'h9999, 4'h0, 4'hF);
        step(25);
        checks++;
        if (sel !== 4'b0100) begin errors++; $display("FAIL pre_reset_sel: %b required 0100", sel); end
        sys_rst_n = 1'b1;
        #1;
        checks += 5;
        if (seg !== 8'h00)     begin errors++; $display("FAIL async_seg: %h required 00", seg); end
        if (sel !== 4'h0)      begin errors++; $display("FAIL async_sel: %b required 0000", sel); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL async_fd: %b required 0", frame_done); end
        if (seg_i !== 8'hFF)   begin errors++; $display("FAIL async_seg_inv: %h required FF", seg_i); end
        if (sel_i !== 4'hF)    begin errors++; $display("FAIL async_sel_inv: %b required 1111", sel_i); end
        step(2);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks += 2;
        if (seg !== 8'hFC)   begin errors++; $display("FAIL post_reset_seg: %h required FC", seg); end
        if (sel !== 4'b0001) begin errors++; $display("FAIL post_reset_sel: %b required 0001", sel); end
        wait_frame_done(1'b0);
        push_frame(16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);
        check_frame("pending_lost", 1'b0, 48);
    endtask

    initial begin
        sys_rst_n = 1'b1;
        data      = 16'h0;
        dp_en     = 4'h0;
        digit_en  = 4'hF;
        lz_blank  = 1'b0;
        load      = 1'b0;
        step(3);
        test_reset;
        test_load_scan;
        test_lz_blank;
        test_digit_en;
        test_back_to_back;
        test_polarity;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
